// File: rtl/alu_execute_stage_if.sv
// Request/write-back bundle between decode, the execute stage and the register file.
interface alu_execute_stage_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic [3:0]        in_opcode;
  logic [DATA_W-1:0] in_reg_1_val;
  logic [DATA_W-1:0] in_reg_2_val;
  logic [ADDR_W-1:0] in_dest_add;
  logic              out_busy;
  logic [ADDR_W-1:0] out_write_reg_add;
  logic [DATA_W-1:0] out_write_reg_val;
  logic              out_write_en;
  logic              out_zero;
  logic              out_carry;

  // Requester side: issues operations, observes write-back and flags.
  modport master (
    output in_valid, in_opcode, in_reg_1_val, in_reg_2_val, in_dest_add,
    input  out_busy, out_write_reg_add, out_write_reg_val, out_write_en,
           out_zero, out_carry
  );

  // Execute stage side.
  modport slave (
    input  in_valid, in_opcode, in_reg_1_val, in_reg_2_val, in_dest_add,
    output out_busy, out_write_reg_add, out_write_reg_val, out_write_en,
           out_zero, out_carry
  );
endinterface

// File: rtl/alu_execute_stage.sv
// Execute stage: single-cycle ALU ops plus an iterative shift-add multiplier,
// writing one result per operation into the register file and tracking Z/C flags.
module alu_execute_stage #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 8,
  parameter int MUL_CYCLES = 16
) (
  input logic               in_clk,
  input logic               in_rst,
  alu_execute_stage_if.slave bus
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam int SH_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_MUL
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6,
    OP_MUL = 4'd7,
    OP_MOV = 4'd8
  } op_e;

  state_e              state_q, state_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [2*DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [ADDR_W-1:0]   dest_q, dest_d;
  logic [ADDR_W-1:0]   wr_add_q, wr_add_d;
  logic [DATA_W-1:0]   wr_val_q, wr_val_d;
  logic                wr_en_q, wr_en_d;
  logic                zero_q, zero_d;
  logic                carry_q, carry_d;

  logic [DATA_W-1:0]   alu_res;
  logic                alu_carry;
  logic                alu_we;
  logic [DATA_W:0]     add_ext, sub_ext, shl_ext, shr_ext;
  logic [SH_W-1:0]     shamt;
  logic [2*DATA_W-1:0] acc_step;

  // Single-cycle ALU result, carry and whether the opcode writes back.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_we    = 1'b1;
    shamt     = bus.in_reg_2_val[SH_W-1:0];
    add_ext   = {1'b0, bus.in_reg_1_val} + {1'b0, bus.in_reg_2_val};
    sub_ext   = {1'b0, bus.in_reg_1_val} - {1'b0, bus.in_reg_2_val};
    // Extra bit beside the operand catches the last bit shifted out; a zero shift leaves it 0.
    shl_ext   = {1'b0, bus.in_reg_1_val} << shamt;
    shr_ext   = {bus.in_reg_1_val, 1'b0} >> shamt;
    case (op_e'(bus.in_opcode))
      OP_ADD: begin alu_res = add_ext[DATA_W-1:0]; alu_carry = add_ext[DATA_W]; end
      OP_SUB: begin alu_res = sub_ext[DATA_W-1:0]; alu_carry = sub_ext[DATA_W]; end
      OP_AND: alu_res = bus.in_reg_1_val & bus.in_reg_2_val;
      OP_OR:  alu_res = bus.in_reg_1_val | bus.in_reg_2_val;
      OP_XOR: alu_res = bus.in_reg_1_val ^ bus.in_reg_2_val;
      OP_SHL: begin alu_res = shl_ext[DATA_W-1:0]; alu_carry = shl_ext[DATA_W]; end
      OP_SHR: begin alu_res = shr_ext[DATA_W:1]; alu_carry = shr_ext[0]; end
      OP_MOV: alu_res = bus.in_reg_2_val;
      default: alu_we = 1'b0;
    endcase
  end

  // Next-state: accept requests in IDLE, iterate the multiplier in MUL.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    dest_d   = dest_q;
    wr_add_d = wr_add_q;
    wr_val_d = wr_val_q;
    wr_en_d  = 1'b0;
    zero_d   = zero_q;
    carry_d  = carry_q;
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (op_e'(bus.in_opcode) == OP_MUL) begin
            state_d  = ST_MUL;
            acc_d    = '0;
            mcand_d  = {{DATA_W{1'b0}}, bus.in_reg_1_val};
            mplier_d = bus.in_reg_2_val;
            count_d  = '0;
            dest_d   = bus.in_dest_add;
          end else if (alu_we) begin
            wr_en_d  = 1'b1;
            wr_add_d = bus.in_dest_add;
            wr_val_d = alu_res;
            zero_d   = (alu_res == '0);
            carry_d  = alu_carry;
          end
        end
      end
      ST_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CNT_W'(1);
        // The final iteration's sum is written directly so the result lands on the same edge.
        if (count_q == CNT_W'(MUL_CYCLES - 1)) begin
          state_d  = ST_IDLE;
          wr_en_d  = 1'b1;
          wr_add_d = dest_q;
          wr_val_d = acc_step[DATA_W-1:0];
          zero_d   = (acc_step[DATA_W-1:0] == '0);
          carry_d  = |acc_step[2*DATA_W-1:DATA_W];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      dest_q   <= '0;
      wr_add_q <= '0;
      wr_val_q <= '0;
      wr_en_q  <= 1'b0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      dest_q   <= dest_d;
      wr_add_q <= wr_add_d;
      wr_val_q <= wr_val_d;
      wr_en_q  <= wr_en_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
    end
  end

  assign bus.out_busy          = (state_q == ST_MUL);
  assign bus.out_write_reg_add = wr_add_q;
  assign bus.out_write_reg_val = wr_val_q;
  assign bus.out_write_en      = wr_en_q;
  assign bus.out_zero          = zero_q;
  assign bus.out_carry         = carry_q;

endmodule
